// File: rtl/counter8_down_async_resetb.sv
// ============================================================================
//  Module      : counter8_down_async_resetb
//  Description : Loadable down-counting timer. It decrements once per clock
//                to zero and pulses tc there, then either stops or reloads.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter8_down_async_resetb #(
    parameter int WIDTH       = 8,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic             pause,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             tc
);

    localparam logic [1:0]       c_st_idle = 2'd0;
    localparam logic [1:0]       c_st_run  = 2'd1;
    localparam logic [1:0]       c_st_hold = 2'd2;
    localparam logic [1:0]       c_st_done = 2'd3;
    localparam logic [WIDTH-1:0] c_zero    = '0;
    localparam logic [WIDTH-1:0] c_one     = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = c_st_idle,
        RUN  = c_st_run,
        HOLD = c_st_hold,
        DONE = c_st_done
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_reload;
    logic [WIDTH-1:0] w_reload_nxt;
    logic [WIDTH-1:0] w_result_nxt;
    logic             w_busy_nxt;
    logic             w_tc_nxt;

    // All outputs are registered; the reset clears them without waiting for clk.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_state  <= IDLE;
            r_reload <= c_zero;
            result   <= c_zero;
            busy     <= 1'b0;
            tc       <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_reload <= w_reload_nxt;
            result   <= w_result_nxt;
            busy     <= w_busy_nxt;
            tc       <= w_tc_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_reload_nxt = r_reload;
        w_result_nxt = result;
        w_busy_nxt   = busy;
        w_tc_nxt     = 1'b0;

        if (load) begin
            w_state_nxt  = IDLE;
            w_reload_nxt = load_value;
            w_result_nxt = load_value;
            w_busy_nxt   = 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    // A zero count cannot start: there would be nothing to time.
                    if (start && (result != c_zero)) begin
                        w_state_nxt = RUN;
                        w_busy_nxt  = 1'b1;
                    end
                end
                RUN: begin
                    if (pause) begin
                        w_state_nxt = HOLD;
                    end else if (result > c_one) begin
                        w_result_nxt = result - c_one;
                    end else if (result == c_one) begin
                        w_tc_nxt = 1'b1;
                        if (AUTO_RELOAD) begin
                            w_result_nxt = r_reload;
                        end else begin
                            w_result_nxt = c_zero;
                            w_state_nxt  = DONE;
                            w_busy_nxt   = 1'b0;
                        end
                    end else begin
                        // Unreachable zero count in RUN: park safely instead of wrapping.
                        w_state_nxt = DONE;
                        w_busy_nxt  = 1'b0;
                    end
                end
                HOLD: begin
                    if (!pause) begin
                        w_state_nxt = RUN;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_busy_nxt  = 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_counter8_down_async_resetb.sv
// ============================================================================
//  Module      : tb_counter8_down_async_resetb
//  Description : Scoreboard bench for the down-counting timer, one-shot and
//                auto-reload instances driven from shared stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_counter8_down_async_resetb;

    logic       clk;
    logic       resetb;
    logic       load;
    logic [7:0] load_value;
    logic       start;
    logic       pause;
    logic [7:0] result0, result1;
    logic       busy0, busy1, tc0, tc1;
    logic       sel;
    logic [7:0] obs_result;
    logic       obs_busy, obs_tc;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic [7:0] r;
        logic       b;
        logic       t;
    } exp_t;

    exp_t sbq[$];

    counter8_down_async_resetb #(.WIDTH(8), .AUTO_RELOAD(1'b0)) dut0 (
        .clk(clk), .resetb(resetb), .load(load), .load_value(load_value),
        .start(start), .pause(pause), .result(result0), .busy(busy0), .tc(tc0)
    );

    counter8_down_async_resetb #(.WIDTH(8), .AUTO_RELOAD(1'b1)) dut1 (
        .clk(clk), .resetb(resetb), .load(load), .load_value(load_value),
        .start(start), .pause(pause), .result(result1), .busy(busy1), .tc(tc1)
    );

    assign obs_result = sel ? result1 : result0;
    assign obs_busy   = sel ? busy1   : busy0;
    assign obs_tc     = sel ? tc1     : tc0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] r, input logic b, input logic t);
        exp_t e;
        e.r = r; e.b = b; e.t = t;
        sbq.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        int   k;
        sel = 1'b0;
        resetb = 1'b1;
        #1 resetb = 1'b0;
        #1;
        n_checks++;
        if (result0 !== 8'h00 || busy0 !== 1'b0 || tc0 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_initial: result=%h busy=%b tc=%b, expected 00 0 0", result0, busy0, tc0);
        end
        step(); step();
        resetb = 1'b1;
        load = 1'b1; load_value = 8'h40;
        step();
        load = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        repeat (9) step();
        n_checks++;
        if (result0 !== 8'h37 || busy0 !== 1'b1) begin
            n_err++;
            $display("FAIL reset_prerun: result=%h busy=%b, expected 37 1", result0, busy0);
        end
        #2 resetb = 1'b0;
        #1;
        n_checks++;
        if (result0 !== 8'h00 || busy0 !== 1'b0 || tc0 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_midrun_async: result=%h busy=%b tc=%b, expected 00 0 0", result0, busy0, tc0);
        end
        #1 resetb = 1'b1;
        start = 1'b1;
        repeat (3) push(8'h00, 1'b0, 1'b0);
        k = 0;
        while (sbq.size() > 0) begin
            step();
            e = sbq.pop_front();
            k++;
            n_checks++;
            if (obs_result !== e.r || obs_busy !== e.b || obs_tc !== e.t) begin
                n_err++;
                $display("FAIL reset_after_release cyc%0d: result=%h busy=%b tc=%b, expected %h %b %b",
                         k, obs_result, obs_busy, obs_tc, e.r, e.b, e.t);
            end
        end
        start = 1'b0;
        // tc must be cleared by reset even in the middle of its pulse
        load = 1'b1; load_value = 8'h01;
        step();
        load = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        n_checks++;
        if (tc0 !== 1'b1) begin
            n_err++;
            $display("FAIL reset_tc_setup: tc=%b, expected 1", tc0);
        end
        #2 resetb = 1'b0;
        #1;
        n_checks++;
        if (tc0 !== 1'b0 || busy0 !== 1'b0 || result0 !== 8'h00) begin
            n_err++;
            $display("FAIL reset_tc_midpulse: result=%h busy=%b tc=%b, expected 00 0 0", result0, busy0, tc0);
        end
        #1 resetb = 1'b1;
    endtask

    task automatic test_one_shot();
        exp_t e;
        int   k;
        sel = 1'b0;
        load = 1'b1; load_value = 8'h05;
        step();
        n_checks++;
        if (result0 !== 8'h05 || busy0 !== 1'b0 || tc0 !== 1'b0) begin
            n_err++;
            $display("FAIL oneshot_load: result=%h busy=%b tc=%b, expected 05 0 0", result0, busy0, tc0);
        end
        load = 1'b0; start = 1'b1;
        push(8'h05, 1'b1, 1'b0);
        for (int v = 4; v >= 1; v--) push(8'(v), 1'b1, 1'b0);
        push(8'h00, 1'b0, 1'b1);
        push(8'h00, 1'b0, 1'b0);
        push(8'h00, 1'b0, 1'b0);
        k = 0;
        while (sbq.size() > 0) begin
            step();
            e = sbq.pop_front();
            k++;
            n_checks++;
            if (obs_result !== e.r || obs_busy !== e.b || obs_tc !== e.t) begin
                n_err++;
                $display("FAIL one_shot cyc%0d: result=%h busy=%b tc=%b, expected %h %b %b",
                         k, obs_result, obs_busy, obs_tc, e.r, e.b, e.t);
            end
            start = (k >= 6);
        end
        start = 1'b0;
    endtask

    task automatic test_auto_reload();
        exp_t e;
        int   k;
        sel = 1'b1;
        load = 1'b1; load_value = 8'h03;
        step();
        n_checks++;
        if (result1 !== 8'h03 || busy1 !== 1'b0) begin
            n_err++;
            $display("FAIL autoreload_load: result=%h busy=%b, expected 03 0", result1, busy1);
        end
        load = 1'b0; start = 1'b1;
        push(8'h03, 1'b1, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            case (i % 3)
                1: push(8'h02, 1'b1, 1'b0);
                2: push(8'h01, 1'b1, 1'b0);
                default: push(8'h03, 1'b1, 1'b1);
            endcase
        end
        k = 0;
        while (sbq.size() > 0) begin
            step();
            e = sbq.pop_front();
            k++;
            n_checks++;
            if (obs_result !== e.r || obs_busy !== e.b || obs_tc !== e.t) begin
                n_err++;
                $display("FAIL auto_reload cyc%0d: result=%h busy=%b tc=%b, expected %h %b %b",
                         k, obs_result, obs_busy, obs_tc, e.r, e.b, e.t);
            end
            start = 1'b0;
        end
        load = 1'b1; load_value = 8'h00;
        step();
        load = 1'b0;
        sel = 1'b0;
    endtask

    task automatic test_pause();
        exp_t             e;
        int               k;
        logic [7:0]       vals [17];
        vals = '{8'h0A, 8'h09, 8'h08, 8'h07, 8'h07, 8'h07, 8'h07, 8'h07, 8'h07,
                 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00, 8'h00};
        sel = 1'b0;
        load = 1'b1; load_value = 8'h0A;
        step();
        load = 1'b0; start = 1'b1;
        for (int i = 0; i < 17; i++)
            push(vals[i], (i < 15), (i == 15));
        k = 0;
        while (sbq.size() > 0) begin
            step();
            e = sbq.pop_front();
            k++;
            n_checks++;
            if (obs_result !== e.r || obs_busy !== e.b || obs_tc !== e.t) begin
                n_err++;
                $display("FAIL pause cyc%0d: result=%h busy=%b tc=%b, expected %h %b %b",
                         k, obs_result, obs_busy, obs_tc, e.r, e.b, e.t);
            end
            start = 1'b0;
            pause = (k >= 4 && k <= 7);
        end
        pause = 1'b0;
    endtask

    task automatic test_corners();
        exp_t e;
        int   k;
        sel = 1'b0;
        // zero start value: start is ignored
        load = 1'b1; load_value = 8'h00;
        step();
        load = 1'b0; start = 1'b1;
        repeat (3) push(8'h00, 1'b0, 1'b0);
        // then full-scale run, then the minimum run
        k = 0;
        while (sbq.size() > 0) begin
            step();
            e = sbq.pop_front();
            k++;
            n_checks++;
            if (obs_result !== e.r || obs_busy !== e.b || obs_tc !== e.t) begin
                n_err++;
                $display("FAIL corner_zero cyc%0d: result=%h busy=%b tc=%b, expected %h %b %b",
                         k, obs_result, obs_busy, obs_tc, e.r, e.b, e.t);
            end
        end
        start = 1'b0;
        load = 1'b1; load_value = 8'hFF;
        step();
        load = 1'b0; start = 1'b1;
        push(8'hFF, 1'b1, 1'b0);
        for (int v = 254; v >= 1; v--) push(8'(v), 1'b1, 1'b0);
        push(8'h00, 1'b0, 1'b1);
        push(8'h00, 1'b0, 1'b0);
        push(8'h00, 1'b0, 1'b0);
        k = 0;
        while (sbq.size() > 0) begin
            step();
            e = sbq.pop_front();
            k++;
            n_checks++;
            if (obs_result !== e.r || obs_busy !== e.b || obs_tc !== e.t) begin
                n_err++;
                $display("FAIL corner_ff cyc%0d: result=%h busy=%b tc=%b, expected %h %b %b",
                         k, obs_result, obs_busy, obs_tc, e.r, e.b, e.t);
            end
            start = 1'b0;
        end
        load = 1'b1; load_value = 8'h01;
        step();
        load = 1'b0; start = 1'b1;
        push(8'h01, 1'b1, 1'b0);
        push(8'h00, 1'b0, 1'b1);
        push(8'h00, 1'b0, 1'b0);
        k = 0;
        while (sbq.size() > 0) begin
            step();
            e = sbq.pop_front();
            k++;
            n_checks++;
            if (obs_result !== e.r || obs_busy !== e.b || obs_tc !== e.t) begin
                n_err++;
                $display("FAIL corner_one cyc%0d: result=%h busy=%b tc=%b, expected %h %b %b",
                         k, obs_result, obs_busy, obs_tc, e.r, e.b, e.t);
            end
            start = 1'b0;
        end
    endtask

    task automatic test_load_abort();
        exp_t e;
        int   k;
        sel = 1'b0;
        load = 1'b1; load_value = 8'h10;
        step();
        load = 1'b0; start = 1'b1;
        push(8'h10, 1'b1, 1'b0);
        push(8'h0F, 1'b1, 1'b0);
        push(8'h0E, 1'b1, 1'b0);
        push(8'h0D, 1'b1, 1'b0);
        push(8'h0C, 1'b1, 1'b0);
        push(8'h02, 1'b0, 1'b0);
        push(8'h02, 1'b0, 1'b0);
        push(8'h02, 1'b1, 1'b0);
        push(8'h01, 1'b1, 1'b0);
        push(8'h00, 1'b0, 1'b1);
        k = 0;
        while (sbq.size() > 0) begin
            step();
            e = sbq.pop_front();
            k++;
            n_checks++;
            if (obs_result !== e.r || obs_busy !== e.b || obs_tc !== e.t) begin
                n_err++;
                $display("FAIL load_abort cyc%0d: result=%h busy=%b tc=%b, expected %h %b %b",
                         k, obs_result, obs_busy, obs_tc, e.r, e.b, e.t);
            end
            case (k)
                1: start = 1'b0;
                5: begin load = 1'b1; load_value = 8'h02; start = 1'b1; end
                6: begin load = 1'b0; start = 1'b0; end
                7: start = 1'b1;
                default: start = 1'b0;
            endcase
        end
        start = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   k;
        sel = 1'b0;
        load = 1'b1; load_value = 8'h03;
        step();
        load = 1'b0; start = 1'b1; pause = 1'b1;
        push(8'h03, 1'b1, 1'b0);
        push(8'h03, 1'b1, 1'b0);
        push(8'h03, 1'b1, 1'b0);
        push(8'h02, 1'b1, 1'b0);
        push(8'h01, 1'b1, 1'b0);
        push(8'h00, 1'b0, 1'b1);
        push(8'h02, 1'b0, 1'b0);
        push(8'h02, 1'b1, 1'b0);
        push(8'h01, 1'b1, 1'b0);
        push(8'h00, 1'b0, 1'b1);
        k = 0;
        while (sbq.size() > 0) begin
            step();
            e = sbq.pop_front();
            k++;
            n_checks++;
            if (obs_result !== e.r || obs_busy !== e.b || obs_tc !== e.t) begin
                n_err++;
                $display("FAIL back_to_back cyc%0d: result=%h busy=%b tc=%b, expected %h %b %b",
                         k, obs_result, obs_busy, obs_tc, e.r, e.b, e.t);
            end
            case (k)
                1: start = 1'b0;
                2: pause = 1'b0;
                6: begin load = 1'b1; load_value = 8'h02; end
                7: begin load = 1'b0; start = 1'b1; end
                8: start = 1'b1;
                default: start = 1'b0;
            endcase
        end
        start = 1'b0;
    endtask

    initial begin
        resetb = 1'b1;
        load = 1'b0;
        load_value = 8'h00;
        start = 1'b0;
        pause = 1'b0;
        sel = 1'b0;
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_pause();
        test_corners();
        test_load_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
